// File: rtl/itof_pipe.sv
// Three-stage integer to IEEE-754 binary32 converter with valid/ready and tag passthrough.
// Build option ITOF_RNE_EN: round to nearest-even instead of ties-away-from-zero.
module itof_pipe #(
  parameter int IW = 32,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_signed,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [TW-1:0] out_tag
);

  localparam int STAGES = 3;
  localparam int LZW    = $clog2(IW);
  localparam int W2     = IW + 25;

  if (IW < 8 || IW > 64) begin : g_bad_iw
    $error("itof_pipe: IW must be in 8..64");
  end

  typedef struct packed {
    logic          s;
    logic [IW-1:0] mag;
    logic [TW-1:0] tag;
  } st1_t;

  // Stage 2 keeps only the rounding-relevant slice of the normalised magnitude.
  typedef struct packed {
    logic           s;
    logic           zero;
    logic [LZW-1:0] lz;
    logic [24:0]    top;
`ifdef ITOF_RNE_EN
    logic           st;
`endif
    logic [TW-1:0]  tag;
  } st2_t;

  logic [STAGES:1] vld_pipe;
  logic            adv;
  st1_t            s1_d, s1_q;
  st2_t            s2_d, s2_q;
  logic [LZW-1:0]  lz;
  logic [23:0]     man24;
  logic            g, up;
  logic [24:0]     sum;
  logic [7:0]      exp_w;
  logic [22:0]     frac;
  logic [31:0]     out_data_d, out_data_q;
  logic [TW-1:0]   out_tag_q;

  assign adv       = out_ready | ~vld_pipe[STAGES];
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

  always_comb begin
    s1_d.s   = in_signed & in_data[IW-1];
    s1_d.mag = s1_d.s ? -in_data : in_data;
    s1_d.tag = in_tag;
  end

  // Highest set bit wins since the scan runs upward.
  always_comb begin
    lz = '0;
    for (int i = 0; i < IW; i++)
      if (s1_q.mag[i]) lz = LZW'(IW - 1 - i);
  end

  always_comb begin
    s2_d.s    = s1_q.s;
    s2_d.zero = (s1_q.mag == '0);
    s2_d.lz   = lz;
    s2_d.top  = 25'(W2'({s1_q.mag, 25'b0} << lz) >> IW);
`ifdef ITOF_RNE_EN
    s2_d.st   = |(W2'({s1_q.mag, 25'b0} << lz) << 25);
`endif
    s2_d.tag  = s1_q.tag;
  end

  always_comb begin
    man24 = s2_q.top[24:1];
    g     = s2_q.top[0];
`ifdef ITOF_RNE_EN
    up    = g & (s2_q.st | man24[0]);
`else
    up    = g;
`endif
    sum   = {1'b0, man24} + {24'b0, up};
    exp_w = 8'(IW + 126) - 8'(s2_q.lz) + {7'b0, sum[24]};
    // A mantissa carry means the value is a power of two, so the fraction collapses to 0.
    frac  = sum[24] ? sum[23:1] : sum[22:0];
    out_data_d = s2_q.zero ? 32'h0 : {s2_q.s, exp_w, frac};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe   <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (vld_pipe[STAGES-1]) begin
        out_data_q <= out_data_d;
        out_tag_q  <= s2_q.tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: doc/itof_pipe.md
Name: itof_pipe

Overview:
- Pipelined, parametrised integer-to-single-precision converter for the FPU datapath.
- Accepts an IW-bit integer, read per transaction as signed or unsigned, and produces an IEEE-754 binary32 result.
- Three register stages with valid/ready handshaking and a passthrough tag, so it can sit behind the issue logic and stall with writeback.

Parameters:
- IW, 32, input integer width; legal range 8..64; elaboration error outside it.
- TW, 4, width of the tag passed through with each transaction.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous reset, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  IW  integer operand.
- in_signed  in  1  1 = two's-complement operand, 0 = unsigned.
- in_tag  in  TW  transaction tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  binary32 result.
- out_tag  out  TW  tag of the result.

Behaviour:
- Reset (rstn low, asynchronous): all stage valids = 0, out_valid = 0, out_data = 0, out_tag = 0. Stage data contents are don't-care except the output registers.
- Pipeline enable: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational.
  - On adv, every stage shifts one step and stage 1 captures (in_valid, in_data, in_signed, in_tag).
  - On ~adv, all stages hold.
- No bubble collapsing; the global stall is acceptable.
- Latency: exactly 3 cycles of adv from acceptance to out_valid. Throughput is 1 per cycle when unstalled. Order is preserved.
- Stage 1 (sign/abs):
  - s = in_signed & in_data[IW-1].
  - mag = s ? -in_data : in_data, as IW-bit unsigned.
  - The most negative value yields mag = 2^(IW-1), which is correct as unsigned.
- Stage 2 (normalise):
  - lz = leading-zero count of mag (0..IW-1).
  - norm = mag << lz, IW bits.
  - zero flag = (mag == 0).
- Stage 3 (round/pack):
  - Extend norm on the right with zeros to at least 26 bits.
  - man24 = top 24 bits.
  - g = next bit (guard).
  - st = OR of all remaining bits (sticky).
  - Round-up rule: g (round half away from zero on the magnitude); see Optional Feature.
  - sum = man24 + up, 25 bits.
  - exp = 127 + (IW-1-lz) + sum[24].
  - frac = sum[24] ? sum[23:1] : sum[22:0]. On carry the value is 2^k, so the fraction is 0.
  - out_data = {s, exp[7:0], frac}.
  - For IW <= 24, g = st = 0 and the result is exact.
- Zero input (either mode): out_data = 0x00000000. Negative zero is never produced.
- Max exponent is 127+64 = 191, so no overflow or Inf is possible. Denormals are impossible.
- out_tag accompanies its data unchanged.
- Reset asserted mid-operation: all in-flight transactions are discarded. After rstn rises, the first out_valid occurs 3 advancing cycles after the next acceptance.
- Holding rule: while out_valid & ~out_ready, out_data and out_tag stay stable.

Optional Feature:
- Macro: ITOF_RNE_EN.
- Defined: round to nearest, ties to even; up = g & (st | man24[0]).
- Undefined: up = g, i.e. ties round away from zero. This matches the existing single-cycle converter bit-for-bit for IW=32 signed.
- No port or latency difference either way.

Test Plan:
- Reset, then IW=32 signed, in_data 0x00000001, out_ready=1 → out_data 0x3F800000 exactly 3 cycles later; in_data 0xFFFFFFFF → 0xBF800000.
- Signed 0x80000000 → 0xCF000000. Signed 0x00000000 → 0x00000000. Signed 0x7FFFFFFF → 0x4F000000.
- Unsigned 0xFFFFFFFF → 0x4F800000 (carry into exponent). Unsigned 0x80000000 → 0x4F000000 (sign bit clear).
- Tie 0x01000001 (16777217) → 0x4B800001 without ITOF_RNE_EN, 0x4B800000 with it. 0x01000003 → 0x4B800002 in both builds.
- Back-to-back inputs tagged 0..7, with out_ready held low for 5 cycles mid-stream:
  - in_ready drops on the cycle adv falls;
  - out_data and out_tag are held stable;
  - all 8 results emerge in tag order with no loss or duplication.
- Assert rstn low for 1 cycle with 3 transactions in flight:
  - out_valid goes 0 asynchronously and out_data reads 0;
  - no stale result appears afterwards;
  - the next input yields a correct result 3 cycles after acceptance.
